// File: rtl/sram_mask_bank.sv
// Single-port-pair SRAM model: byte-masked writes, registered reads, and a
// clear-on-reset sequencer. Optional macro SRAM_WFWD_EN selects write-first.
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   ren, raddr              read request and address
//   wen, waddr, wdata       write request, address and data
//   wmask                   byte enables, bit i covers wdata[8i+7:8i]
//   rdata, rvalid           registered read data and one-cycle valid pulse
//   init_done               array cleared, requests accepted
// Configuration:
//   SRAM_WFWD_EN defined    same-address read/write returns the merged word
//   SRAM_WFWD_EN undefined  same-address read/write returns the old word
module sram_mask_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LEN = 6,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ren,
    input  logic [ADDR_LEN-1:0]   raddr,
    input  logic                  wen,
    input  logic [ADDR_LEN-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  init_done
);

    localparam int DEPTH = 1 << ADDR_LEN;
    localparam logic [ADDR_LEN:0] LAST = (ADDR_LEN + 1)'(DEPTH - 1);
    localparam logic [ADDR_LEN:0] ONE = (ADDR_LEN + 1)'(1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [ADDR_LEN:0] cnt;
    logic [ADDR_LEN:0] cnt_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic                  wr_req;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign init_done = (state == RUN);
    assign clr_we    = (state == INIT);
    // An all-zero mask is a no-op, so it never counts as a write.
    assign wr_req    = wen & init_done & (|wmask);
    assign rd_req    = ren & init_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter is one bit wider than the address so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + ONE;
            if (cnt == LAST) begin
                state_nxt = RUN;
            end
        end
    end

    always_comb begin
        old_word = mem[raddr];
        wr_word  = mem[waddr];
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wmask[i]) begin
                wr_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

`ifdef SRAM_WFWD_EN
    // Write-first: a colliding read sees the bytes being written this edge.
    assign rd_word = (wr_req && (waddr == raddr)) ? wr_word : old_word;
`else
    assign rd_word = old_word;
`endif

    // Contents have no reset; INIT clears them one entry per edge.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt[ADDR_LEN-1:0]] <= '0;
        end else if (wr_req) begin
            mem[waddr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_req;
            if (rd_req) begin
                rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sram_mask_bank.sv
// Self-checking bench for sram_mask_bank: directed cases plus random traffic
// compared against a byte-level array model of the memory.
module tb_sram_mask_bank;

    logic        clk;
    logic        resetn;
    logic        ren;
    logic [5:0]  raddr;
    logic        wen;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        rvalid;
    logic        init_done;

    int nchk;
    int npass;
    logic [31:0] mdl [64];
    logic [31:0] exp_rd;

    sram_mask_bank #(
        .DATA_WIDTH(32),
        .ADDR_LEN(6)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ren(ren),
        .raddr(raddr),
        .wen(wen),
        .waddr(waddr),
        .wdata(wdata),
        .wmask(wmask),
        .rdata(rdata),
        .rvalid(rvalid),
        .init_done(init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic model_clear();
        for (int a = 0; a < 64; a++) mdl[a] = 32'h0;
        exp_rd = 32'h0;
    endtask

    // One RUN-state cycle: predict from the model, apply, compare.
    task automatic op(input logic r, input logic [5:0] ra, input logic w,
                      input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] wm);
        logic [31:0] merged;
        logic [31:0] lane;
        ren = r; raddr = ra; wen = w; waddr = wa; wdata = wd; wmask = wm;
        merged = mdl[wa];
        for (int i = 0; i < 4; i++) begin
            lane = 32'hFF << (8 * i);
            if (wm[i]) merged = (merged & ~lane) | (wd & lane);
        end
        if (r) begin
`ifdef SRAM_WFWD_EN
            exp_rd = (w && wa == ra) ? merged : mdl[ra];
`else
            exp_rd = mdl[ra];
`endif
        end
        if (w) mdl[wa] = merged;
        step();
        check("rvalid", {31'b0, rvalid}, {31'b0, r});
        check("rdata", rdata, exp_rd);
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic init_phase(input logic poke);
        for (int e = 1; e <= 64; e++) begin
            ren = poke; raddr = 6'd63;
            wen = poke; waddr = 6'd63; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
            step();
            check("init_done", {31'b0, init_done}, {31'b0, (e == 64)});
            check("init_rvalid", {31'b0, rvalid}, 32'h0);
        end
        ren = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        nchk = 0;
        npass = 0;
        resetn = 1'b0;
        ren = 1'b0; raddr = '0;
        wen = 1'b0; waddr = '0; wdata = '0; wmask = '0;
        model_clear();
        #3;
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_init_done", {31'b0, init_done}, 32'h0);
        step();
        step();
        resetn = 1'b1;

        init_phase(1'b1);

        for (int a = 0; a < 64; a++) op(1'b1, 6'(a), 1'b0, 6'd0, 32'h0, 4'h0);
        check("idle_rdata_hold", rdata, 32'h0);

        op(1'b0, 6'd0, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF);
        op(1'b0, 6'd0, 1'b1, 6'd5, 32'h1122_3344, 4'h5);
        op(1'b1, 6'd5, 1'b0, 6'd0, 32'h0, 4'h0);
        check("mask_merge", rdata, 32'hDE22_BE44);

        op(1'b0, 6'd0, 1'b1, 6'd9, 32'hAAAA_AAAA, 4'hF);
        op(1'b1, 6'd9, 1'b1, 6'd9, 32'h1234_5678, 4'h3);
`ifdef SRAM_WFWD_EN
        check("collide", rdata, 32'hAAAA_5678);
`else
        check("collide", rdata, 32'hAAAA_AAAA);
`endif
        op(1'b1, 6'd9, 1'b0, 6'd0, 32'h0, 4'h0);
        check("collide_after", rdata, 32'hAAAA_5678);

        op(1'b0, 6'd0, 1'b1, 6'd3, 32'hCAFE_F00D, 4'hF);
        op(1'b0, 6'd0, 1'b1, 6'd3, 32'h0, 4'h0);
        op(1'b1, 6'd3, 1'b0, 6'd0, 32'h0, 4'h0);
        check("mask_zero", rdata, 32'hCAFE_F00D);

        op(1'b1, 6'd63, 1'b0, 6'd0, 32'h0, 4'h0);
        check("init_write_blocked", rdata, 32'h0);

        op(1'b1, 6'd0, 1'b1, 6'd1, 32'h5555_AAAA, 4'hF);
        op(1'b1, 6'd1, 1'b1, 6'd2, 32'h0F0F_0F0F, 4'hF);
        op(1'b1, 6'd2, 1'b0, 6'd0, 32'h0, 4'h0);
        op(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 4'h0);

        for (int n = 0; n < 400; n++) begin
            op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
               $urandom, 4'($urandom_range(0, 15)));
        end

        op(1'b0, 6'd0, 1'b1, 6'd5, 32'h7777_7777, 4'hF);
        op(1'b1, 6'd5, 1'b0, 6'd0, 32'h0, 4'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("midrun_rdata", rdata, 32'h0);
        check("midrun_rvalid", {31'b0, rvalid}, 32'h0);
        check("midrun_init_done", {31'b0, init_done}, 32'h0);
        model_clear();
        step();
        resetn = 1'b1;
        init_phase(1'b0);
        op(1'b1, 6'd5, 1'b0, 6'd0, 32'h0, 4'h0);
        op(1'b1, 6'd9, 1'b0, 6'd0, 32'h0, 4'h0);
        op(1'b1, 6'd3, 1'b0, 6'd0, 32'h0, 4'h0);

        for (int e = 0; e < 10; e++) step();
        resetn = 1'b0;
        #1;
        check("midinit_init_done", {31'b0, init_done}, 32'h0);
        step();
        resetn = 1'b1;
        init_phase(1'b0);
        op(1'b1, 6'd1, 1'b0, 6'd0, 32'h0, 4'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
